// File: rtl/deint_symbol_packer.sv
// Packs one OFDM symbol of demapper bit groups into the deinterleaver's wide input word.
// Optional build macro PACKER_BITREV_EN reverses the bit order within each subcarrier group.

module deint_packer_lane #(
   parameter int J = 0
) (
   input  logic [2:0] nb,
   input  logic [5:0] bits,
   output logic       bit_o,
   output logic       en
);
   logic [2:0] ridx;

   assign en = (3'(J) < nb);
`ifdef PACKER_BITREV_EN
   assign ridx = nb - 3'(J) - 3'd1;
`else
   assign ridx = 3'(J);
`endif
   assign bit_o = en ? bits[ridx] : 1'b0;
endmodule

module deint_symbol_packer #(
   parameter int NSD   = 48,
   parameter int OUT_W = 289
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       nbpsc,
   input  logic             sym_start,
   input  logic             in_valid,
   input  logic [5:0]       in_bits,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_word,
   output logic [8:0]       out_ncbps,
   output logic             err
);
   localparam int VEC_W = 6;

   typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

   state_t           state;
   logic [2:0]       nb_r;
   logic [5:0]       sc_cnt;
   logic [OUT_W-1:0] fill, fill_nx;

   logic             xfer, start, legal, out_free;
   logic [2:0]       nb_use;
   logic [5:0]       sc_use;
   logic [8:0]       base;
   logic [VEC_W-1:0] lane_bit, lane_en;

   function automatic logic [8:0] ncbps(input logic [2:0] n);
      return ({6'd0, n} << 5) + ({6'd0, n} << 4);
   endfunction

   assign in_ready = (state != HOLD);
   assign xfer     = in_valid & in_ready;
   assign start    = xfer & sym_start;
   assign legal    = (nbpsc == 3'd1) || (nbpsc == 3'd2) || (nbpsc == 3'd4) || (nbpsc == 3'd6);
   assign out_free = !out_valid || out_ready;
   assign nb_use   = start ? nbpsc : nb_r;
   assign sc_use   = start ? 6'd0 : sc_cnt;
   assign base     = 9'(sc_use) * 9'(nb_use);

   for (genvar j = 0; j < VEC_W; j++) begin : g_lane
      deint_packer_lane #(.J(j)) u_lane (
         .nb   (nb_use),
         .bits (in_bits),
         .bit_o(lane_bit[j]),
         .en   (lane_en[j])
      );
   end

   // A new symbol starts from an all-zero buffer so unused upper bits read as 0.
   always_comb begin
      fill_nx = start ? '0 : fill;
      for (int j = 0; j < VEC_W; j++)
         if (lane_en[j]) fill_nx[base + 9'(j)] = lane_bit[j];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         nb_r      <= '0;
         sc_cnt    <= '0;
         fill      <= '0;
         out_valid <= 1'b0;
         out_word  <= '0;
         out_ncbps <= '0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE, FILL: if (xfer) begin
               if (sym_start && !legal) begin
                  err    <= 1'b1;
                  sc_cnt <= '0;
                  state  <= IDLE;
               end else if (sym_start || state == FILL) begin
                  if (sym_start) begin
                     nb_r <= nbpsc;
                     err  <= (state == FILL);
                  end
                  if (sc_use == 6'(NSD - 1)) begin
                     sc_cnt <= '0;
                     if (out_free) begin
                        out_word  <= fill_nx;
                        out_ncbps <= ncbps(nb_use);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                     end else begin
                        fill  <= fill_nx;
                        state <= HOLD;
                     end
                  end else begin
                     fill   <= fill_nx;
                     sc_cnt <= sc_use + 6'd1;
                     state  <= FILL;
                  end
               end
            end
            HOLD: if (out_valid && out_ready) begin
               out_word  <= fill;
               out_ncbps <= ncbps(nb_r);
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
